// File: rtl/riscv_pkg.sv
// riscv_pkg: shared EduRISC-V datapath constants and types.
//   XLEN       - architectural register / datapath width
//   perf_cnt_t - 32-bit performance counter type
package riscv_pkg;

   localparam int XLEN = 32;

   typedef logic [31:0] perf_cnt_t;

endpackage

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: one elastic stage made of a main register and a skid register.
//   clk        in   clock, all state updates on posedge
//   reset      in   synchronous active-low reset (0 = reset)
//   flush      in   drop buffered beats (valid bits clear, data kept)
//   in_valid   in   upstream beat present
//   in_ready   out  registered; high while the skid register is empty
//   in_data    in   upstream payload
//   out_valid  out  main register holds a beat
//   out_ready  in   downstream accepts the main register
//   out_data   out  main register payload
module pipe_skid_stage
   import riscv_pkg::*;
#(
   parameter int               WIDTH     = XLEN,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q;
   logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
   logic             acc, pop, load;

   assign acc  = in_valid && rdy_q;
   assign pop  = main_v_q && out_ready;
   // main slot is free to be refilled this cycle (empty or being drained)
   assign load = !main_v_q || pop;

   // acc implies the skid is empty, so skid and input never compete for main
   always_comb begin
      main_v_d = load ? (skid_v_q || acc) : main_v_q;
      main_d   = (load && skid_v_q) ? skid_q : ((load && acc) ? in_data : main_q);
      skid_v_d = load ? 1'b0 : (skid_v_q || acc);
      skid_d   = (!load && acc) ? in_data : skid_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         rdy_q    <= 1'b0;
         main_q   <= RESET_VAL;
         skid_q   <= RESET_VAL;
      end else if (flush) begin
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         rdy_q    <= !skid_v_d;
         main_q   <= main_d;
         skid_q   <= skid_d;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = main_v_q;
   assign out_data  = main_q;

endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: elastic pipeline register, STAGES chained skid stages, full throughput.
//   clk            in   clock
//   reset          in   synchronous active-low reset (0 = reset)
//   flush          in   drop all buffered beats
//   in_valid/in_ready/in_data     upstream handshake (in_ready is registered)
//   out_valid/out_ready/out_data  downstream handshake
//   perf_stall_cnt out  saturating count of out_valid && !out_ready cycles,
//                       present only when PIPE_REG_PERF_EN is defined
module pipe_reg
   import riscv_pkg::*;
#(
   parameter int               WIDTH     = XLEN,
   parameter int               STAGES    = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_PERF_EN
   ,
   output perf_cnt_t        perf_stall_cnt
`endif
);

   // link i is the input side of stage i; link STAGES is the block output
   logic [STAGES:0]  v, r;
   logic [WIDTH-1:0] d [STAGES+1];

   assign v[0]      = in_valid;
   assign d[0]      = in_data;
   assign r[STAGES] = out_ready;
   assign in_ready  = r[0];
   assign out_valid = v[STAGES];
   assign out_data  = d[STAGES];

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      pipe_skid_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk       (clk),
         .reset     (reset),
         .flush     (flush),
         .in_valid  (v[i]),
         .in_ready  (r[i]),
         .in_data   (d[i]),
         .out_valid (v[i+1]),
         .out_ready (r[i+1]),
         .out_data  (d[i+1])
      );
   end

`ifdef PIPE_REG_PERF_EN
   perf_cnt_t cnt_q, cnt_d;

   // flush deliberately leaves the counter running; only reset clears it
   always_comb cnt_d = (out_valid && !out_ready && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign perf_stall_cnt = cnt_q;
`endif

endmodule
